// File: rtl/cbus_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cbus_sram_responder_pkg
// Purpose  : Shared CBUS types (request/response structs, burst length and
//            access size encodings) plus bus width constants used by the
//            SRAM responder and its storage array.
// Revision : 1.0 - initial release
// ============================================================================
package cbus_sram_responder_pkg;

  localparam int CBUS_DW    = 32;
  localparam int CBUS_AW    = 32;
  localparam int CBUS_BYTES = CBUS_DW / 8;

  // Burst length: encoded value is (beats - 1)
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    msize_t                size;
    logic [CBUS_AW-1:0]    addr;
    logic [CBUS_BYTES-1:0] strobe;
    logic [CBUS_DW-1:0]    data;
    cbus_len_t             len;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/cbus_sram_array.sv
`default_nettype none
// ============================================================================
// Module   : cbus_sram_array
// Purpose  : MEM_WORDS x 32-bit storage, combinational read, synchronous
//            byte-strobed write. Contents are never reset.
// Ports    : clk    - write clock (rising edge)
//            we     - write enable for the current cycle
//            addr   - word address (read and write)
//            strobe - per-byte write enables
//            wdata  - write data
//            rdata  - read data, combinational from addr
// Revision : 1.0 - initial release
// ============================================================================
module cbus_sram_array
  import cbus_sram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [CBUS_BYTES-1:0]        strobe,
  input  logic [CBUS_DW-1:0]           wdata,
  output logic [CBUS_DW-1:0]           rdata
);

  logic [CBUS_DW-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < CBUS_BYTES; i++) begin
        if (strobe[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/cbus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : cbus_sram_responder
// Purpose  : CBUS target backed by a word-addressed SRAM. Accepts a burst
//            request in IDLE, optionally idles WAIT_CYCLES cycles, then
//            serves one beat per cycle with an auto-incrementing, wrapping
//            word pointer. Dropping valid mid-transfer aborts the burst.
// Ports    : clk    - sole clock, rising edge
//            resetn - asynchronous active-low reset
//            creq   - initiator request (valid, is_write, size, addr,
//                     strobe, data, len)
//            cresp  - response (ready, last, data)
// Revision : 1.0 - initial release
// ============================================================================
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int AW = $clog2(MEM_WORDS);
  // Value of the wait counter on the final WAIT cycle
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_ptr;
  logic [3:0]        r_left;       // beats remaining after the current one
  logic [3:0]        r_wait_cnt;
  logic              r_is_write;
  logic              w_beat;
  logic              w_final;
  logic [CBUS_DW-1:0] w_rdata;
  logic              w_unused;

  // A beat only happens while the initiator still holds valid, so a drop of
  // valid in BURST produces neither a ready nor a write that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        if (creq.valid) begin
          if (WAIT_CYCLES > 0) w_state_nxt = WAIT;
          else                 w_state_nxt = BURST;
        end
      end
      WAIT: begin
        if (!creq.valid)                  w_state_nxt = IDLE;
        else if (r_wait_cnt == WAIT_LAST) w_state_nxt = BURST;
      end
      BURST: begin
        if (!creq.valid) begin
          w_state_nxt = IDLE;
        end else begin
          w_beat = 1'b1;
          if (r_left == 4'd0) w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!creq.valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_final = w_beat && (r_left == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_left     <= '0;
      r_wait_cnt <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && creq.valid) begin
        r_ptr      <= creq.addr[AW+1:2];
        r_left     <= creq.len;
        r_is_write <= creq.is_write;
        r_wait_cnt <= '0;
      end
      if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      if (w_beat) begin
        r_ptr <= r_ptr + AW'(1);   // wraps modulo MEM_WORDS
        if (r_left != 4'd0) r_left <= r_left - 4'd1;
      end
    end
  end

  cbus_sram_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk    (clk),
    .we     (w_beat && r_is_write),
    .addr   (r_ptr),
    .strobe (creq.strobe),
    .wdata  (creq.data),
    .rdata  (w_rdata)
  );

  assign cresp.ready = w_beat;
  assign cresp.last  = w_final;
  assign cresp.data  = (w_beat && !r_is_write) ? w_rdata : '0;

  // Access size and sub-word / out-of-range address bits do not affect
  // word-granular addressing.
  assign w_unused = &{1'b0, creq.size, creq.addr[CBUS_AW-1:AW+2], creq.addr[1:0]};

endmodule
`default_nettype wire
